ddio_clk_sequencer: RTL and testbench

- Controller that drives the data inputs of the DDR output register (altddio_out) used to generate the SDRAM clock.
- Sequences the clock through four phases: parked, warm-up, running and drain.
- Controls SDRAM CKE and output enable, and gives the memory controller a start/stop request interface with a ready flag and a stopped pulse.
- Sits between the SDRAM controller and the DDIO clock-output instance.

---
 rtl/ddio_clk_pkg.sv | 20 ++
 rtl/ddio_seq_counter.sv | 27 ++
 rtl/ddio_clk_sequencer.sv | 139 +++++++++++++
 tb/tb_ddio_clk_sequencer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddio_clk_pkg.sv
// rtl/ddio_clk_pkg.sv - shared types and helpers for the DDIO clock sequencer
package ddio_clk_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WARMUP = 2'd1,
    RUN    = 2'd2,
    DRAIN  = 2'd3
  } seq_state_t;

  // Level driven on datain_h while running; datain_l always carries the inverse.
  function automatic logic run_high_level(input logic clk_inv);
    return ~clk_inv;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ddio_seq_counter.sv
// rtl/ddio_seq_counter.sv - loadable down-counter with zero flag, saturating at zero
module ddio_seq_counter #(
  parameter int CNT_W = 4
) (
  input  logic             outclock,
  input  logic             aclr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge outclock or posedge aclr) begin
    if (aclr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/ddio_clk_sequencer.sv
// rtl/ddio_clk_sequencer.sv - parks, warms up, runs and drains the SDRAM clock
// driven through altddio_out, with CKE/ready handshake to the memory controller.
module ddio_clk_sequencer
  import ddio_clk_pkg::*;
#(
  parameter int WIDTH         = 1,
  parameter int WARMUP_CYCLES = 16,
  parameter int DRAIN_CYCLES  = 4,
  parameter bit CLK_INV       = 1'b1,
  parameter bit PARK_LEVEL    = 1'b0
) (
  input  logic             outclock,
  input  logic             aclr,
  input  logic             start_req,
  input  logic             stop_req,
  output logic [WIDTH-1:0] ddio_h,
  output logic [WIDTH-1:0] ddio_l,
  output logic             ddio_oe,
  output logic             cke,
  output logic             ready,
  output logic             busy,
  output logic             stopped
);

  localparam int               MAX_CYC    = max_int(WARMUP_CYCLES, DRAIN_CYCLES);
  localparam int               CNT_W      = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] WARM_LOAD  = CNT_W'(WARMUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic             RUN_H      = run_high_level(CLK_INV);
  localparam logic             RUN_L      = ~RUN_H;

  seq_state_t       state, state_nxt;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_load_val;

  logic [WIDTH-1:0] h_nxt, l_nxt;
  logic             oe_nxt, cke_nxt, busy_nxt, stopped_nxt;

  ddio_seq_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .outclock (outclock),
    .aclr     (aclr),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // Stop is evaluated ahead of warm-up expiry so an abort never lets CKE rise.
  always_comb begin
    state_nxt    = state;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    case (state)
      IDLE: begin
        if (start_req) begin
          state_nxt    = WARMUP;
          cnt_load     = 1'b1;
          cnt_load_val = WARM_LOAD;
        end
      end
      WARMUP: begin
        if (stop_req) begin
          state_nxt    = DRAIN;
          cnt_load     = 1'b1;
          cnt_load_val = DRAIN_LOAD;
        end else if (cnt_zero) begin
          state_nxt = RUN;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      RUN: begin
        if (stop_req) begin
          state_nxt    = DRAIN;
          cnt_load     = 1'b1;
          cnt_load_val = DRAIN_LOAD;
        end
      end
      DRAIN: begin
        if (cnt_zero) begin
          state_nxt = IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every output is a flop aligned with state.
  always_comb begin
    h_nxt       = {WIDTH{PARK_LEVEL}};
    l_nxt       = {WIDTH{PARK_LEVEL}};
    oe_nxt      = 1'b0;
    cke_nxt     = 1'b0;
    busy_nxt    = 1'b0;
    stopped_nxt = 1'b0;
    if (state_nxt != IDLE) begin
      h_nxt  = {WIDTH{RUN_H}};
      l_nxt  = {WIDTH{RUN_L}};
      oe_nxt = 1'b1;
    end
    if (state_nxt == RUN) begin
      cke_nxt = 1'b1;
    end
    if ((state_nxt == WARMUP) || (state_nxt == DRAIN)) begin
      busy_nxt = 1'b1;
    end
    if ((state == DRAIN) && (state_nxt == IDLE)) begin
      stopped_nxt = 1'b1;
    end
  end

  always_ff @(posedge outclock or posedge aclr) begin
    if (aclr) begin
      state   <= IDLE;
      ddio_h  <= {WIDTH{PARK_LEVEL}};
      ddio_l  <= {WIDTH{PARK_LEVEL}};
      ddio_oe <= 1'b0;
      cke     <= 1'b0;
      ready   <= 1'b0;
      busy    <= 1'b0;
      stopped <= 1'b0;
    end else begin
      state   <= state_nxt;
      ddio_h  <= h_nxt;
      ddio_l  <= l_nxt;
      ddio_oe <= oe_nxt;
      cke     <= cke_nxt;
      ready   <= cke_nxt;
      busy    <= busy_nxt;
      stopped <= stopped_nxt;
    end
  end

endmodule

// File: tb/tb_ddio_clk_sequencer.sv
// tb/tb_ddio_clk_sequencer.sv - self-checking bench for ddio_clk_sequencer
module tb_ddio_clk_sequencer;

  logic outclock = 1'b0;
  logic aclr = 1'b1;
  logic start_req = 1'b0;
  logic stop_req = 1'b0;

  always #5 outclock = ~outclock;

  logic       h1, l1, oe1, cke1, rdy1, busy1, stp1;
  logic [3:0] h2, l2;
  logic       oe2, cke2, rdy2, busy2, stp2;

  ddio_clk_sequencer u_dut1 (
    .outclock (outclock), .aclr (aclr), .start_req (start_req), .stop_req (stop_req),
    .ddio_h (h1), .ddio_l (l1), .ddio_oe (oe1), .cke (cke1), .ready (rdy1),
    .busy (busy1), .stopped (stp1)
  );

  ddio_clk_sequencer #(
    .WIDTH (4), .WARMUP_CYCLES (1), .DRAIN_CYCLES (1), .CLK_INV (1'b0), .PARK_LEVEL (1'b0)
  ) u_dut2 (
    .outclock (outclock), .aclr (aclr), .start_req (start_req), .stop_req (stop_req),
    .ddio_h (h2), .ddio_l (l2), .ddio_oe (oe2), .cke (cke2), .ready (rdy2),
    .busy (busy2), .stopped (stp2)
  );

  // {h, l, oe, cke, ready, busy, stopped}
  logic [6:0]  obs1;
  logic [12:0] obs2;
  assign obs1 = {h1, l1, oe1, cke1, rdy1, busy1, stp1};
  assign obs2 = {h2, l2, oe2, cke2, rdy2, busy2, stp2};

  localparam logic [6:0]  V1_PARK    = 7'b0000000;
  localparam logic [6:0]  V1_BUSY    = 7'b0110010;
  localparam logic [6:0]  V1_RUN     = 7'b0111100;
  localparam logic [6:0]  V1_STOPPED = 7'b0000001;
  localparam logic [12:0] V2_BUSY    = 13'b1111_0000_10010;
  localparam logic [12:0] V2_RUN     = 13'b1111_0000_11100;
  localparam logic [12:0] V2_STOPPED = 13'b0000_0000_00001;

  int checks = 0;
  int errors = 0;

  // Reference: phase 0=parked 1=warm-up 2=running 3=drain, plus edges elapsed in phase.
  int m_phase[2];
  int m_elapsed[2];
  bit m_stopped[2];
  int m_warm[2]  = '{16, 1};
  int m_drain[2] = '{4, 1};

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_phase[i] = 0; m_elapsed[i] = 0; m_stopped[i] = 0;
    end
  endtask

  task automatic model_edge(input int i, input logic s, input logic p);
    m_stopped[i] = 0;
    case (m_phase[i])
      0: if (s) begin m_phase[i] = 1; m_elapsed[i] = 0; end
      1: begin
        m_elapsed[i]++;
        if (p) begin m_phase[i] = 3; m_elapsed[i] = 0; end
        else if (m_elapsed[i] == m_warm[i]) m_phase[i] = 2;
      end
      2: if (p) begin m_phase[i] = 3; m_elapsed[i] = 0; end
      default: begin
        m_elapsed[i]++;
        if (m_elapsed[i] == m_drain[i]) begin m_phase[i] = 0; m_stopped[i] = 1; end
      end
    endcase
  endtask

  function automatic logic [6:0] model_vec1();
    logic on;
    on = (m_phase[0] != 0);
    return {1'b0, on, on, m_phase[0] == 2, m_phase[0] == 2,
            (m_phase[0] == 1) || (m_phase[0] == 3), m_stopped[0]};
  endfunction

  function automatic logic [12:0] model_vec2();
    logic on;
    on = (m_phase[1] != 0);
    return {{4{on}}, 4'b0000, on, m_phase[1] == 2, m_phase[1] == 2,
            (m_phase[1] == 1) || (m_phase[1] == 3), m_stopped[1]};
  endfunction

  task automatic step();
    logic s, p;
    s = start_req;
    p = stop_req;
    @(posedge outclock);
    model_edge(0, s, p);
    model_edge(1, s, p);
    #1;
  endtask

  task automatic do_reset();
    @(negedge outclock);
    aclr = 1'b1; start_req = 1'b0; stop_req = 1'b0;
    model_reset();
    @(negedge outclock);
    aclr = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (obs1 !== V1_PARK) begin errors++; $display("FAIL reset_held_dut1: got %b expected %b", obs1, V1_PARK); end
    checks++;
    if (obs2 !== 13'd0) begin errors++; $display("FAIL reset_held_dut2: got %b expected %b", obs2, 13'd0); end
    @(negedge outclock);
    aclr = 1'b0;
    model_reset();
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (obs1 !== V1_PARK) begin errors++; $display("FAIL reset_idle_%0d: got %b expected %b", k, obs1, V1_PARK); end
    end
    start_req = 1'b1;
    step();
    start_req = 1'b0;
    for (int k = 0; k < 16; k++) step();
    checks++;
    if (obs1 !== V1_RUN) begin errors++; $display("FAIL reset_pre_run: got %b expected %b", obs1, V1_RUN); end
    #2 aclr = 1'b1;
    #1;
    checks++;
    if (obs1 !== V1_PARK) begin errors++; $display("FAIL aclr_async_dut1: got %b expected %b", obs1, V1_PARK); end
    checks++;
    if (obs2 !== 13'd0) begin errors++; $display("FAIL aclr_async_dut2: got %b expected %b", obs2, 13'd0); end
    model_reset();
    @(negedge outclock);
    aclr = 1'b0;
  endtask

  task automatic test_warmup();
    do_reset();
    start_req = 1'b1;
    step();
    start_req = 1'b0;
    checks++;
    if (obs1 !== V1_BUSY) begin errors++; $display("FAIL warmup_entry_dut1: got %b expected %b", obs1, V1_BUSY); end
    checks++;
    if (obs2 !== V2_BUSY) begin errors++; $display("FAIL warmup_entry_dut2: got %b expected %b", obs2, V2_BUSY); end
    step();
    checks++;
    if (obs2 !== V2_RUN) begin errors++; $display("FAIL warmup1_run_dut2: got %b expected %b", obs2, V2_RUN); end
    for (int k = 2; k < 16; k++) step();
    checks++;
    if (obs1 !== V1_BUSY) begin errors++; $display("FAIL warmup_t15: got %b expected %b", obs1, V1_BUSY); end
    step();
    checks++;
    if (obs1 !== V1_RUN) begin errors++; $display("FAIL warmup_t16_run: got %b expected %b", obs1, V1_RUN); end
  endtask

  task automatic test_stop_run();
    stop_req = 1'b1;
    step();
    stop_req = 1'b0;
    checks++;
    if (obs1 !== V1_BUSY) begin errors++; $display("FAIL drain_entry_dut1: got %b expected %b", obs1, V1_BUSY); end
    checks++;
    if (obs2 !== V2_BUSY) begin errors++; $display("FAIL drain_entry_dut2: got %b expected %b", obs2, V2_BUSY); end
    step();
    checks++;
    if (obs2 !== V2_STOPPED) begin errors++; $display("FAIL drain1_park_dut2: got %b expected %b", obs2, V2_STOPPED); end
    for (int k = 1; k < 4; k++) begin
      if (k > 1) step();
      checks++;
      if (obs1 !== V1_BUSY) begin errors++; $display("FAIL drain_hold_s%0d: got %b expected %b", k, obs1, V1_BUSY); end
    end
    step();
    checks++;
    if (obs1 !== V1_STOPPED) begin errors++; $display("FAIL drain_s4_stopped: got %b expected %b", obs1, V1_STOPPED); end
    step();
    checks++;
    if (obs1 !== V1_PARK) begin errors++; $display("FAIL stopped_one_cycle: got %b expected %b", obs1, V1_PARK); end
  endtask

  task automatic test_abort_warmup();
    do_reset();
    start_req = 1'b1;
    step();
    start_req = 1'b0;
    for (int k = 1; k < 5; k++) step();
    stop_req = 1'b1;
    step();
    stop_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (obs1 !== V1_BUSY) begin errors++; $display("FAIL abort_drain_%0d: got %b expected %b", k, obs1, V1_BUSY); end
      step();
    end
    checks++;
    if (obs1 !== V1_STOPPED) begin errors++; $display("FAIL abort_stopped: got %b expected %b", obs1, V1_STOPPED); end
    start_req = 1'b1;
    step();
    start_req = 1'b0;
    for (int k = 1; k < 16; k++) step();
    stop_req = 1'b1;
    step();
    stop_req = 1'b0;
    checks++;
    if (obs1 !== V1_BUSY) begin errors++; $display("FAIL stop_on_expiry: got %b expected %b", obs1, V1_BUSY); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    start_req = 1'b1;
    stop_req = 1'b1;
    step();
    stop_req = 1'b0;
    checks++;
    if (obs1 !== V1_BUSY) begin errors++; $display("FAIL start_wins: got %b expected %b", obs1, V1_BUSY); end
    for (int k = 0; k < 16; k++) step();
    checks++;
    if (obs1 !== V1_RUN) begin errors++; $display("FAIL held_start_run: got %b expected %b", obs1, V1_RUN); end
    stop_req = 1'b1;
    step();
    stop_req = 1'b0;
    for (int k = 0; k < 4; k++) step();
    checks++;
    if (obs1 !== V1_STOPPED) begin errors++; $display("FAIL held_start_stopped: got %b expected %b", obs1, V1_STOPPED); end
    step();
    checks++;
    if (obs1 !== V1_BUSY) begin errors++; $display("FAIL restart_warmup: got %b expected %b", obs1, V1_BUSY); end
    start_req = 1'b0;
  endtask

  task automatic test_random();
    logic [6:0]  e1;
    logic [12:0] e2;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      start_req = ($urandom_range(0, 99) < 15);
      stop_req  = ($urandom_range(0, 99) < 8);
      step();
      e1 = model_vec1();
      e2 = model_vec2();
      checks++;
      if (obs1 !== e1) begin errors++; $display("FAIL random_dut1 cyc %0d: got %b expected %b", n, obs1, e1); end
      checks++;
      if (obs2 !== e2) begin errors++; $display("FAIL random_dut2 cyc %0d: got %b expected %b", n, obs2, e2); end
    end
    start_req = 1'b0;
    stop_req = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_warmup();
    test_stop_run();
    test_abort_warmup();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
